// File: rtl/gearbox_132_block_sync_if.sv
// Bus between the 128->132 gearbox output and the block-lock controller.
// master: gearbox / link-layer side driving blocks and clears.
// slave:  the block-lock controller.
interface gearbox_132_block_sync_if;
    logic [131:0] blk;
    logic         blk_valid;
    logic         err_clr;
    logic         slip;
    logic         locked;
    logic         hdr_type;
    logic         hdr_err;
    logic [15:0]  err_cnt;

    modport master (
        output blk,
        output blk_valid,
        output err_clr,
        input  slip,
        input  locked,
        input  hdr_type,
        input  hdr_err,
        input  err_cnt
    );

    modport slave (
        input  blk,
        input  blk_valid,
        input  err_clr,
        output slip,
        output locked,
        output hdr_type,
        output hdr_err,
        output err_cnt
    );
endinterface

// File: rtl/gearbox_132_block_sync.sv
// Block-lock controller for the 128->132 gearbox output.
// Hunts for a consistent 4-bit sync header by requesting bit-slips, verifies
// LOCK_CNT consecutive good headers, then monitors lock over ERR_WIN-block
// windows and drops lock after ERR_MAX bad headers within one window.
// Optional macro GEARBOX_132_HDR_1BIT_TOL_EN: accept headers within Hamming
// distance 1 of a valid code, classified as the nearer code.
module gearbox_132_block_sync #(
    parameter int unsigned LOCK_CNT  = 32,
    parameter int unsigned ERR_WIN   = 64,
    parameter int unsigned ERR_MAX   = 8,
    parameter int unsigned SLIP_WAIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gearbox_132_block_sync_if.slave   bus
);

    localparam logic [3:0] HDR_DATA = 4'b0011;
    localparam logic [3:0] HDR_CTRL = 4'b1100;

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int unsigned WIN_W  = $clog2(ERR_WIN);
    localparam int unsigned BAD_W  = $clog2(ERR_MAX + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(ERR_WIN - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(ERR_MAX - 1);
    localparam logic [BAD_W-1:0]  BAD_ONE   = BAD_W'(1);
    localparam logic [15:0]       ERR_ONE   = 16'd1;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP_WAIT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t            state;
    logic [GOOD_W-1:0] good_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [BAD_W-1:0]  bad_cnt;

    logic        slip;
    logic        locked;
    logic        hdr_type;
    logic        hdr_err;
    logic [15:0] err_cnt;

    logic [3:0]  hdr;
    logic        hdr_good;
    logic        hdr_ctrl;

    // Payload bits are carried for the link layer and not inspected here.
    logic        unused_payload;

    assign hdr            = bus.blk[131:128];
    assign unused_payload = ^bus.blk[127:0];

    assign bus.slip     = slip;
    assign bus.locked   = locked;
    assign bus.hdr_type = hdr_type;
    assign bus.hdr_err  = hdr_err;
    assign bus.err_cnt  = err_cnt;

`ifdef GEARBOX_132_HDR_1BIT_TOL_EN
    function automatic int unsigned hamming4(input logic [3:0] a, input logic [3:0] b);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (a[i] != b[i]) begin
                n = n + 1;
            end
        end
        return n;
    endfunction
`endif

    // Classify the sync header of the current block as good/bad and data/control.
    always_comb begin
        hdr_good = 1'b0;
        hdr_ctrl = 1'b0;
`ifdef GEARBOX_132_HDR_1BIT_TOL_EN
        // The two codes are 4 apart, so the distance-1 balls never overlap.
        if (hamming4(hdr, HDR_DATA) <= 1) begin
            hdr_good = 1'b1;
        end else if (hamming4(hdr, HDR_CTRL) <= 1) begin
            hdr_good = 1'b1;
            hdr_ctrl = 1'b1;
        end
`else
        if (hdr == HDR_DATA) begin
            hdr_good = 1'b1;
        end else if (hdr == HDR_CTRL) begin
            hdr_good = 1'b1;
            hdr_ctrl = 1'b1;
        end
`endif
    end

    // Lock FSM with registered outputs; only qualified blocks advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            good_cnt <= '0;
            wait_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            slip     <= 1'b0;
            locked   <= 1'b0;
            hdr_type <= 1'b0;
            hdr_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            slip    <= 1'b0;
            hdr_err <= 1'b0;

            // Clear has priority over a same-cycle increment below.
            if (bus.err_clr) begin
                err_cnt <= '0;
            end

            if (bus.blk_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (hdr_good) begin
                            state    <= ST_VERIFY;
                            good_cnt <= GOOD_ONE;
                        end else begin
                            slip     <= 1'b1;
                            state    <= ST_SLIP_WAIT;
                            wait_cnt <= '0;
                        end
                    end

                    ST_SLIP_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            wait_cnt <= '0;
                            state    <= ST_HUNT;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_ONE;
                        end
                    end

                    ST_VERIFY: begin
                        if (hdr_good) begin
                            if (good_cnt == GOOD_LAST) begin
                                state    <= ST_LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                                win_cnt  <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                good_cnt <= good_cnt + GOOD_ONE;
                            end
                        end else begin
                            slip     <= 1'b1;
                            state    <= ST_SLIP_WAIT;
                            wait_cnt <= '0;
                            good_cnt <= '0;
                        end
                    end

                    ST_LOCKED: begin
                        if (hdr_good) begin
                            hdr_type <= hdr_ctrl;
                        end else begin
                            hdr_err <= 1'b1;
                            if (!bus.err_clr && (err_cnt != '1)) begin
                                err_cnt <= err_cnt + ERR_ONE;
                            end
                        end

                        // Loss is checked before the window rollover so a
                        // loss on the last block of a window still wins.
                        if (!hdr_good && (bad_cnt == BAD_LAST)) begin
                            locked   <= 1'b0;
                            slip     <= 1'b1;
                            state    <= ST_SLIP_WAIT;
                            wait_cnt <= '0;
                            win_cnt  <= '0;
                            bad_cnt  <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_ONE;
                            if (!hdr_good) begin
                                bad_cnt <= bad_cnt + BAD_ONE;
                            end
                        end
                    end

                    default: begin
                        state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gearbox_132_block_sync.sv
// Directed, table-driven bench for gearbox_132_block_sync (default parameters).
// Expectations for the 1-bit tolerance vectors follow GEARBOX_132_HDR_1BIT_TOL_EN.
module tb_gearbox_132_block_sync;

    logic clk;
    logic rst_n;

    gearbox_132_block_sync_if bus ();

    gearbox_132_block_sync #(
        .LOCK_CNT  (32),
        .ERR_WIN   (64),
        .ERR_MAX   (8),
        .SLIP_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  hdr;
        logic        valid;
        logic        clr;
        logic        slip;
        logic        locked;
        logic        hdr_type;
        logic        hdr_err;
        logic [15:0] err_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic [3:0] h, input logic v, input logic c,
                       input logic s, input logic l, input logic t,
                       input logic e, input logic [15:0] n);
        vec_t x;
        x.hdr = h; x.valid = v; x.clr = c;
        x.slip = s; x.locked = l; x.hdr_type = t; x.hdr_err = e; x.err_cnt = n;
        vecs.push_back(x);
    endtask

    task automatic check(input string tag, input int idx, input string name,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input vec_t x);
        check(tag, idx, "slip",     {15'd0, bus.slip},     {15'd0, x.slip});
        check(tag, idx, "locked",   {15'd0, bus.locked},   {15'd0, x.locked});
        check(tag, idx, "hdr_type", {15'd0, bus.hdr_type}, {15'd0, x.hdr_type});
        check(tag, idx, "hdr_err",  {15'd0, bus.hdr_err},  {15'd0, x.hdr_err});
        check(tag, idx, "err_cnt",  bus.err_cnt,           x.err_cnt);
    endtask

    // Drive each vector at the falling edge, compare 1 time unit after the rising edge.
    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.blk       = {vecs[i].hdr, $urandom(), $urandom(), $urandom(), $urandom()};
            bus.blk_valid = vecs[i].valid;
            bus.err_clr   = vecs[i].clr;
            @(posedge clk);
            #1;
            check_outputs(tag, i, vecs[i]);
        end
        @(negedge clk);
        bus.blk_valid = 1'b0;
        bus.err_clr   = 1'b0;
        vecs.delete();
    endtask

    task automatic check_reset_state(input string tag);
        vec_t z;
        z.hdr = 4'h0; z.valid = 1'b0; z.clr = 1'b0;
        z.slip = 1'b0; z.locked = 1'b0; z.hdr_type = 1'b0; z.hdr_err = 1'b0; z.err_cnt = 16'd0;
        check_outputs(tag, 0, z);
    endtask

    initial begin
        bus.blk       = '0;
        bus.blk_valid = 1'b0;
        bus.err_clr   = 1'b0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Straight lock on data headers: locked rises after the 32nd block.
        for (int i = 1; i <= 32; i++) add(4'b0011, 1, 0, 0, (i == 32), 0, 0, 16'd0);

        // Locked: 8 bad headers interleaved with good ones drop lock on the 8th.
        for (int k = 1; k <= 8; k++) begin
            add(4'b0011, 1, 0, 0, 1, 0, 0, 16'(k - 1));
            if (k < 8) add(4'b0000, 1, 0, 0, 1, 0, 1, 16'(k));
            else       add(4'b0000, 1, 0, 1, 0, 0, 1, 16'd8);
        end
        // SLIP_WAIT: four valid blocks ignored, no further slip.
        for (int i = 0; i < 4; i++) add(4'b0000, 1, 0, 0, 0, 0, 0, 16'd8);

        // HUNT: bad header slips once, 4 ignored blocks, then 32 control headers lock.
        add(4'b0101, 1, 0, 1, 0, 0, 0, 16'd8);
        for (int i = 0; i < 4; i++) add(4'b1111, 1, 0, 0, 0, 0, 0, 16'd8);
        for (int i = 1; i <= 32; i++) add(4'b1100, 1, 0, 0, (i == 32), 0, 0, 16'd8);

        // Window 1 (64 blocks): control header, bad+err_clr, 56 good, 6 bad -> 7 bad total.
        add(4'b1100, 1, 0, 0, 1, 1, 0, 16'd8);
        add(4'b0000, 1, 1, 0, 1, 1, 1, 16'd0);
        for (int i = 0; i < 56; i++) add(4'b1100, 1, 0, 0, 1, 1, 0, 16'd0);
        for (int k = 1; k <= 6; k++) add(4'b0000, 1, 0, 0, 1, 1, 1, 16'(k));
        // Window 2: 7 more bad must not drop lock if bad_cnt was cleared.
        for (int k = 7; k <= 13; k++) add(4'b0000, 1, 0, 0, 1, 1, 1, 16'(k));
        add(4'b0011, 1, 0, 0, 1, 0, 0, 16'd13);
        // Unqualified bad header is ignored.
        add(4'b0000, 0, 0, 0, 1, 0, 0, 16'd13);
        add(4'b1100, 1, 0, 0, 1, 1, 0, 16'd13);
        add(4'b0011, 0, 0, 0, 1, 1, 0, 16'd13);
        run_table("main");

        // Reset while LOCKED aborts immediately, without waiting for a clock edge.
        rst_n = 1'b0;
        #1 check_reset_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // blk_valid toggling: 32 valid blocks across 63 cycles, invalid cycles carry bad headers.
        for (int i = 1; i <= 32; i++) begin
            add(4'b0011, 1, 0, 0, (i == 32), 0, 0, 16'd0);
            if (i < 32) add(4'b0000, 0, 0, 0, 0, 0, 0, 16'd0);
        end
        add(4'b1100, 1, 0, 0, 1, 1, 0, 16'd0);
`ifdef GEARBOX_132_HDR_1BIT_TOL_EN
        add(4'b0111, 1, 0, 0, 1, 0, 0, 16'd0);
        add(4'b0000, 1, 0, 0, 1, 0, 1, 16'd1);
        add(4'b1101, 1, 0, 0, 1, 1, 0, 16'd1);
`else
        add(4'b0111, 1, 0, 0, 1, 1, 1, 16'd1);
        add(4'b0000, 1, 0, 0, 1, 1, 1, 16'd2);
        add(4'b1101, 1, 0, 0, 1, 1, 1, 16'd3);
`endif
        run_table("toggle_tol");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
